memresp: RTL and testbench

Memory responder serving the multicycle processor's unified instruction/data memory port. It accepts one word-wide read or write request at a time, inserts a programmable number of wait states, and returns a single-cycle `ready` pulse with read data and an error flag. It sits between the datapath's memory-address/write-data outputs and its `readdata` input, and replaces the zero-latency combinational memory with a handshaked one.

---
 rtl/memresp_if.sv | 13 +
 rtl/memresp.sv | 70 +++++++
 tb/tb_memresp.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/memresp_if.sv
// memresp_if: request/response bundle between a requester and the memory responder.
interface memresp_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/memresp.sv
// memresp: handshaked word memory with programmable wait states and fault detection.
module memresp #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic       clk,
  input logic       reset,
  memresp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        lwe;
  logic [31:0] laddr;
  logic [31:0] lwdata;
  logic [31:0] mem [DEPTH];
  logic        fault;
  logic        acc;
  assign fault = (|laddr[1:0]) || (|(laddr >> (AW + 2)));
  assign acc   = (state == BUSY) && (cnt == 4'd0);
  // Reset forces state to IDLE, so an aborted transaction never reaches the write.
  always_ff @(posedge clk)
    if (acc && lwe && !fault) mem[laddr[AW+1:2]] <= lwdata;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lwe       <= 1'b0;
      laddr     <= 32'd0;
      lwdata    <= 32'd0;
      bus.rdata <= 32'd0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.ready <= 1'b0;
          bus.err   <= 1'b0;
          if (bus.req) begin
            lwe      <= bus.we;
            laddr    <= bus.addr;
            lwdata   <= bus.wdata;
            cnt      <= 4'(LATENCY);
            bus.busy <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            state     <= RESP;
            bus.ready <= 1'b1;
            bus.err   <= fault;
            if (fault) bus.rdata <= 32'd0;
            else if (!lwe) bus.rdata <= mem[laddr[AW+1:2]];
          end
        end
        RESP: begin
          state     <= IDLE;
          bus.ready <= 1'b0;
          bus.err   <= 1'b0;
          bus.busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memresp.sv
// tb_memresp: directed checks of memresp at LATENCY 0, 2 and 15.
module tb_memresp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  memresp_if i0 ();
  memresp_if i2 ();
  memresp_if i15 ();
  memresp #(.DEPTH(64), .LATENCY(0))  d0  (.clk(clk), .reset(reset), .bus(i0));
  memresp #(.DEPTH(64), .LATENCY(2))  d2  (.clk(clk), .reset(reset), .bus(i2));
  memresp #(.DEPTH(64), .LATENCY(15)) d15 (.clk(clk), .reset(reset), .bus(i15));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    case (s)
      0:       begin i0.req = r;  i0.we = w;  i0.addr = a;  i0.wdata = d;  end
      2:       begin i2.req = r;  i2.we = w;  i2.addr = a;  i2.wdata = d;  end
      default: begin i15.req = r; i15.we = w; i15.addr = a; i15.wdata = d; end
    endcase
  endtask

  task automatic sample(input int s, output logic b, output logic r, output logic e, output logic [31:0] d);
    case (s)
      0:       begin b = i0.busy;  r = i0.ready;  e = i0.err;  d = i0.rdata;  end
      2:       begin b = i2.busy;  r = i2.ready;  e = i2.err;  d = i2.rdata;  end
      default: begin b = i15.busy; r = i15.ready; e = i15.err; d = i15.rdata; end
    endcase
  endtask

  task automatic wait_idle(input int s);
    logic b, r, e;
    logic [31:0] d;
    int g = 0;
    sample(s, b, r, e, d);
    while (b && g < 50) begin
      @(negedge clk);
      g++;
      sample(s, b, r, e, d);
    end
  endtask

  // Called at a negedge; returns at the negedge where ready is seen, with k = edges after acceptance.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] wd, input bit tog,
                     output logic [31:0] rd, output logic er, output int k);
    logic b, r;
    wait_idle(s);
    drive(s, 1'b1, w, a, wd);
    @(posedge clk);
    k = 0;
    @(negedge clk);
    sample(s, b, r, er, rd);
    chk("busy_after_accept", 32'(b), 32'd1);
    while (!r && k < 40) begin
      if (tog) drive(s, k[0], w, k[0] ? 32'h40 : 32'h48, $urandom);
      @(posedge clk);
      k++;
      @(negedge clk);
      sample(s, b, r, er, rd);
    end
    chk("ready_seen", 32'(r), 32'd1);
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er, b, r;
    int k, n, idle;
    int rc [3];
    logic [31:0] rv [3];
    drive(0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    drive(15, 0, 0, 0, 0);
    #1;
    sample(2, b, r, er, rd);
    chk("rst_busy", 32'(b), 32'd0);
    chk("rst_ready", 32'(r), 32'd0);
    chk("rst_err", 32'(er), 32'd0);
    chk("rst_rdata", rd, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // Abort a pending write with reset mid-BUSY
    txn(2, 1, 32'h10, 32'hAAAA0000, 0, rd, er, k);
    txn(2, 0, 32'h10, 32'd0, 0, rd, er, k);
    chk("pre_rst_read", rd, 32'hAAAA0000);
    wait_idle(2);
    drive(2, 1, 1, 32'h10, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(2, 0, 0, 0, 0);
    #1;
    sample(2, b, r, er, rd);
    chk("midbusy_rst_busy", 32'(b), 32'd0);
    chk("midbusy_rst_ready", 32'(r), 32'd0);
    chk("midbusy_rst_rdata", rd, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    txn(2, 0, 32'h10, 32'd0, 0, rd, er, k);
    chk("aborted_write_read", rd, 32'hAAAA0000);
    // LATENCY=2 write then read
    txn(2, 1, 32'h20, 32'hCAFEF00D, 0, rd, er, k);
    chk("l2_write_lat", 32'(k), 32'd3);
    chk("l2_write_err", 32'(er), 32'd0);
    txn(2, 0, 32'h20, 32'd0, 0, rd, er, k);
    chk("l2_read_lat", 32'(k), 32'd3);
    chk("l2_read_data", rd, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    sample(2, b, r, er, rd);
    chk("ready_one_cycle", 32'(r), 32'd0);
    // Misaligned and out-of-range faults
    txn(2, 1, 32'h22, 32'hDEADBEEF, 0, rd, er, k);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    txn(2, 0, 32'h20, 32'd0, 0, rd, er, k);
    chk("after_misalign_data", rd, 32'hCAFEF00D);
    chk("after_misalign_err", 32'(er), 32'd0);
    txn(2, 0, 32'h100, 32'd0, 0, rd, er, k);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    txn(2, 1, 32'hFC, 32'h600DF00D, 0, rd, er, k);
    txn(2, 0, 32'hFC, 32'd0, 0, rd, er, k);
    chk("top_word_err", 32'(er), 32'd0);
    chk("top_word_data", rd, 32'h600DF00D);
    // LATENCY=0 back-to-back reads with req held
    txn(0, 1, 32'h0, 32'd1, 0, rd, er, k);
    chk("l0_write_lat", 32'(k), 32'd1);
    txn(0, 1, 32'h4, 32'd2, 0, rd, er, k);
    txn(0, 1, 32'h8, 32'd3, 0, rd, er, k);
    wait_idle(0);
    drive(0, 1, 0, 32'h0, 32'd0);
    n = 0;
    idle = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      sample(0, b, r, er, rd);
      if (n > 0 && !b) idle++;
      if (r) begin
        rc[n] = c;
        rv[n] = rd;
        n++;
        drive(0, n < 3, 0, 32'(n * 4), 32'd0);
      end
    end
    chk("b2b_count", 32'(n), 32'd3);
    if (n == 3) begin
      chk("b2b_data0", rv[0], 32'd1);
      chk("b2b_data1", rv[1], 32'd2);
      chk("b2b_data2", rv[2], 32'd3);
      chk("b2b_gap1", 32'(rc[1] - rc[0]), 32'd3);
      chk("b2b_gap2", 32'(rc[2] - rc[1]), 32'd3);
    end
    chk("b2b_idle_cycles", 32'(idle), 32'd2);
    drive(0, 0, 0, 0, 0);
    // LATENCY=15 with inputs toggled during BUSY
    txn(15, 1, 32'h40, 32'h00000055, 0, rd, er, k);
    chk("l15_lat", 32'(k), 32'd16);
    txn(15, 1, 32'h44, 32'h11111111, 1, rd, er, k);
    chk("l15_tog_lat", 32'(k), 32'd16);
    chk("l15_tog_err", 32'(er), 32'd0);
    txn(15, 0, 32'h44, 32'd0, 0, rd, er, k);
    chk("l15_tog_data", rd, 32'h11111111);
    txn(15, 0, 32'h40, 32'd0, 0, rd, er, k);
    chk("l15_other_word", rd, 32'h00000055);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
